// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings, flit type decode helper and
// packet counter width. The guarded macros below supply the params.svh values
// when that header is not already part of the build.
`ifndef DW
`define DW 32
`endif
`ifndef HEAD
`define HEAD 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b01
`endif
`ifndef PKT_LEN
`define PKT_LEN 4
`endif

package noc_pkg;

  localparam int PKT_CNT_W = 16;

  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_TAIL = `TAIL,
    FLIT_HEAD = `HEAD
  } flit_type_t;

  // Any code that is neither HEAD nor TAIL is treated as a body flit.
  function automatic flit_type_t flit_type(input logic [`DW-1:0] data);
    logic [1:0] code;
    code = data[`DW-1:`DW-2];
    if (code == `HEAD) return FLIT_HEAD;
    else if (code == `TAIL) return FLIT_TAIL;
    else return FLIT_BODY;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating credit up/down counter. Starts full at CREDIT_NUM; an increment
// at full saturates and raises ovf_err for that cycle. Simultaneous inc and
// dec leave the count unchanged.
module credit_counter #(
  parameter int CREDIT_NUM = 16,
  parameter int CW         = $clog2(CREDIT_NUM + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          ovf_err
);

  localparam logic [CW-1:0] CNT_MAX = CW'(CREDIT_NUM);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count with saturation at both ends.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_err = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == CNT_MAX) ovf_err = 1'b1;
      else cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, reset full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= CNT_MAX;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ni_credit_sender.sv
// Router local output stage feeding the network interface receive port.
// Flits are gated by a credit counter (the interface never back-pressures),
// registered with latency 1, and checked for HEAD/TAIL framing.
// Optional macro NI_PKT_ADMIT_EN: a HEAD in IDLE is admitted only when a whole
// packet's worth of credits (`PKT_LEN) is available; requires
// CREDIT_NUM >= `PKT_LEN.
module ni_credit_sender
  import noc_pkg::*;
#(
  parameter int CREDIT_NUM = 16,
  parameter int CW         = $clog2(CREDIT_NUM + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 valid_i,
  input  logic [`DW-1:0]       data_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [`DW-1:0]       data_o,
  input  logic                 credit_upd,
  output logic [CW-1:0]        credit_o,
  output logic [PKT_CNT_W-1:0] pkt_cnt_o,
  output logic                 err_o
);

  typedef enum logic {ST_IDLE, ST_BODY} state_t;

  state_t                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic [`DW-1:0]         data_q, data_d;
  logic [PKT_CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic                   err_q, err_d;
  logic                   accept;
  logic                   frame_err;
  logic                   ovf_err;
  flit_type_t             ft;

  credit_counter #(.CREDIT_NUM(CREDIT_NUM), .CW(CW)) u_credit (
    .clk     (clk),
    .rstn    (rstn),
    .inc     (credit_upd),
    .dec     (accept),
    .cnt     (credit_o),
    .ovf_err (ovf_err)
  );

  // Admission: per-flit by default, whole-packet for a HEAD when enabled.
  always_comb begin
`ifdef NI_PKT_ADMIT_EN
    ready_o = (state_q == ST_BODY) ? (credit_o != '0)
                                   : (credit_o >= CW'(`PKT_LEN));
`else
    ready_o = (credit_o != '0);
`endif
  end

  assign accept = valid_i & ready_o;
  assign ft     = flit_type(data_i);

  // Framing FSM, output register and sticky error next-state.
  always_comb begin
    state_d   = state_q;
    pkt_cnt_d = pkt_cnt_q;
    frame_err = 1'b0;
    valid_d   = accept;
    data_d    = accept ? data_i : data_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (ft == FLIT_HEAD) state_d = ST_BODY;
          else                 frame_err = 1'b1;
        end
        ST_BODY: begin
          if (ft == FLIT_TAIL) begin
            state_d   = ST_IDLE;
            pkt_cnt_d = pkt_cnt_q + 1'b1;
          end else if (ft == FLIT_HEAD) begin
            frame_err = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    err_d = err_q | frame_err | ovf_err;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      data_q    <= '0;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_q     <= err_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign pkt_cnt_o = pkt_cnt_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_ni_credit_sender.sv
// Directed testbench for ni_credit_sender (CREDIT_NUM=16, `PKT_LEN=4).
// The packet-admission section runs only when NI_PKT_ADMIT_EN is defined.
`ifndef DW
`define DW 32
`endif
`ifndef HEAD
`define HEAD 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b01
`endif
`ifndef PKT_LEN
`define PKT_LEN 4
`endif

module tb_ni_credit_sender;

  localparam int CN = 16;
  localparam int CW = $clog2(CN + 1);
  localparam int DW = `DW;
  localparam logic [1:0] T_H = `HEAD;
  localparam logic [1:0] T_T = `TAIL;
  localparam logic [1:0] T_B = 2'b00;

  logic          clk, rstn, valid_i, ready_o, valid_o, credit_upd, err_o;
  logic [DW-1:0] data_i, data_o;
  logic [CW-1:0] credit_o;
  logic [15:0]   pkt_cnt_o;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] f[20];

  ni_credit_sender #(.CREDIT_NUM(CN)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .credit_upd (credit_upd),
    .credit_o   (credit_o),
    .pkt_cnt_o  (pkt_cnt_o),
    .err_o      (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every flit pushed to the interface.
  always @(negedge clk) if (rstn && valid_o) rx_q.push_back(data_o);

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int p);
    return {t, (DW-2)'(p)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid_i    = 1'b0;
    credit_upd = 1'b0;
    data_i     = '0;
    rstn       = 1'b0;
    #12;
    rx_q.delete();
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  // Present one flit and hold it until accepted (bounded wait).
  task automatic send(input logic [DW-1:0] fl);
    int w;
    w = 0;
    valid_i = 1'b1;
    data_i  = fl;
    while (!ready_o && w < 50) begin
      step();
      w++;
    end
    if (!ready_o) begin
      chk("send_ready_timeout", ready_o, 1);
    end else begin
      step();
      exp_q.push_back(fl);
    end
    valid_i = 1'b0;
  endtask

  task automatic chk_rx(input string tag);
    chk({tag, "_rx_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_rx%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  initial begin
    rstn = 1'b1; valid_i = 1'b0; credit_upd = 1'b0; data_i = '0;

    // 1: reset values, then one packet H,B,B,T.
    do_reset();
    chk("rst_credit", credit_o, CN);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_pkt", pkt_cnt_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ready", ready_o, 1);
    send(mk(T_H, 1));
    chk("t1_lat_valid", valid_o, 1);
    chk("t1_lat_data", data_o, mk(T_H, 1));
    send(mk(T_B, 2));
    send(mk(T_B, 3));
    send(mk(T_T, 4));
    step();
    chk("t1_idle_valid", valid_o, 0);
    chk("t1_hold_data", data_o, mk(T_T, 4));
    chk_rx("t1");
    chk("t1_credit", credit_o, 12);
    chk("t1_pkt", pkt_cnt_o, 1);
    chk("t1_err", err_o, 0);

    // 2: 20 flits back-to-back, credits run out after 16.
    do_reset();
    for (int i = 0; i < 20; i++)
      f[i] = mk((i == 0) ? T_H : (i == 19) ? T_T : T_B, 16'h100 + i);
    for (int i = 0; i < 16; i++) begin
      valid_i = 1'b1;
      data_i  = f[i];
      step();
      exp_q.push_back(f[i]);
    end
    data_i = f[16];
    chk("t2_credit0", credit_o, 0);
    chk("t2_ready0", ready_o, 0);
    step();
    step();
    chk("t2_stall_valid", valid_o, 0);
    chk("t2_stall_credit", credit_o, 0);
    for (int i = 16; i < 20; i++) begin
      data_i     = f[i];
      credit_upd = 1'b1;
      step();
      credit_upd = 1'b0;
      chk($sformatf("t2_ready_after_upd%0d", i), ready_o, 1);
      step();
      exp_q.push_back(f[i]);
    end
    valid_i = 1'b0;
    step();
    chk_rx("t2");
    chk("t2_credit_end", credit_o, 0);
    chk("t2_pkt", pkt_cnt_o, 1);
    chk("t2_err", err_o, 0);

    // 3: simultaneous accept+credit_upd, then overflow at full.
    do_reset();
    send(mk(T_H, 5));
    for (int i = 0; i < 10; i++) send(mk(T_B, 6 + i));
    chk("t3_credit5", credit_o, 5);
    valid_i = 1'b1; data_i = mk(T_B, 16'h55); credit_upd = 1'b1;
    step();
    exp_q.push_back(mk(T_B, 16'h55));
    valid_i = 1'b0; credit_upd = 1'b0;
    chk("t3_both_credit", credit_o, 5);
    chk("t3_both_valid", valid_o, 1);
    credit_upd = 1'b1;
    for (int i = 0; i < 11; i++) step();
    credit_upd = 1'b0;
    chk("t3_full_credit", credit_o, CN);
    chk("t3_full_err", err_o, 0);
    credit_upd = 1'b1;
    step();
    credit_upd = 1'b0;
    chk("t3_ovf_credit", credit_o, CN);
    chk("t3_ovf_err", err_o, 1);
    step();
    chk("t3_err_sticky", err_o, 1);

    // 4: framing errors.
    do_reset();
    send(mk(T_B, 16'h77));
    chk("t4a_valid", valid_o, 1);
    chk("t4a_data", data_o, mk(T_B, 16'h77));
    chk("t4a_err", err_o, 1);
    chk("t4a_pkt", pkt_cnt_o, 0);
    do_reset();
    chk("t4b_err_cleared", err_o, 0);
    send(mk(T_H, 21));
    send(mk(T_B, 22));
    chk("t4b_err_before", err_o, 0);
    send(mk(T_H, 23));
    chk("t4b_err_head", err_o, 1);
    send(mk(T_B, 24));
    send(mk(T_T, 25));
    step();
    chk("t4b_pkt", pkt_cnt_o, 1);
    chk("t4b_err_end", err_o, 1);
    chk_rx("t4b");

    // 5: asynchronous reset mid-packet.
    do_reset();
    send(mk(T_H, 31));
    send(mk(T_B, 32));
    chk("t5_credit14", credit_o, 14);
    chk("t5_valid_pre", valid_o, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_rst_credit", credit_o, CN);
    chk("t5_rst_valid", valid_o, 0);
    chk("t5_rst_data", data_o, 0);
    chk("t5_rst_pkt", pkt_cnt_o, 0);
    chk("t5_rst_err", err_o, 0);
    rx_q.delete();
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    step();
    send(mk(T_H, 41));
    send(mk(T_B, 42));
    send(mk(T_B, 43));
    send(mk(T_T, 44));
    step();
    chk_rx("t5");
    chk("t5_pkt", pkt_cnt_o, 1);
    chk("t5_credit", credit_o, 12);
    chk("t5_err", err_o, 0);

`ifdef NI_PKT_ADMIT_EN
    // 6: HEAD held until a full packet of credits is available.
    do_reset();
    send(mk(T_H, 50));
    for (int i = 0; i < 11; i++) send(mk(T_B, 51 + i));
    send(mk(T_T, 62));
    chk("t6_credit3", credit_o, 3);
    valid_i = 1'b1;
    data_i  = mk(T_H, 63);
    chk("t6_head_held", ready_o, 0);
    step();
    chk("t6_hold_credit", credit_o, 3);
    chk("t6_hold_valid", valid_o, 0);
    credit_upd = 1'b1;
    step();
    credit_upd = 1'b0;
    chk("t6_credit4", credit_o, 4);
    chk("t6_ready", ready_o, 1);
    step();
    exp_q.push_back(mk(T_H, 63));
    valid_i = 1'b0;
    chk("t6_head_valid", valid_o, 1);
    chk("t6_head_data", data_o, mk(T_H, 63));
    chk("t6_head_credit", credit_o, 3);
    send(mk(T_B, 64));
    send(mk(T_B, 65));
    send(mk(T_T, 66));
    step();
    chk("t6_credit_end", credit_o, 0);
    chk("t6_pkt", pkt_cnt_o, 2);
    chk("t6_err", err_o, 0);
    chk_rx("t6");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ni_credit_sender.md
Name: ni_credit_sender

Overview:
- Router-side local output stage that drives the network interface's network-end receive port (one instance per network: cast or gather).
- Accepts flits from the router crossbar's local output with a valid/ready handshake and pushes them to the interface.
- The interface never back-pressures (its ready is tied high), so this block gates flits with a credit counter replenished by the interface's credit_upd pulse.
- Tracks packet framing (HEAD/TAIL) and flags protocol and credit errors.

Parameters:
- CREDIT_NUM, 16, initial and maximum credit count; equals the interface receive-buffer slots reserved for this link.
- CW, $clog2(CREDIT_NUM+1), credit counter width; derived, do not override.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- valid_i  input  1  flit valid from crossbar local output
- data_i  input  `DW  flit from crossbar; [`DW-1:`DW-2] is the flit type
- ready_o  output  1  flit accepted when valid_i & ready_o
- valid_o  output  1  one-cycle push to interface (valid_i_*_nw)
- data_o  output  `DW  flit to interface (data_i_*_nw)
- credit_upd  input  1  one-cycle credit return from interface, one per flit read
- credit_o  output  CW  current credit count
- pkt_cnt_o  output  16  number of TAIL flits sent, wraps 0xFFFF->0
- err_o  output  1  sticky protocol/credit error

Behaviour:
- Reset values: credit_o=CREDIT_NUM, valid_o=0, data_o=0, pkt_cnt_o=0, err_o=0, state=IDLE.
- Reset is asynchronous at any time, including mid-packet: a partially sent packet is abandoned and credits are restored to CREDIT_NUM.
- Handshake:
  - ready_o = (credit_o != 0), combinational; does not depend on valid_i.
  - Accept = valid_i & ready_o.
  - Registered output, latency 1: the cycle after an accept, valid_o=1 and data_o=accepted flit.
  - With no accept, valid_o=0 next cycle and data_o holds its last value.
  - Throughput: one flit per cycle while credits last.
- Credits:
  - Accept alone: credit−1.
  - credit_upd alone: credit+1.
  - Accept and credit_upd in the same cycle: unchanged.
  - credit_upd at credit_o==CREDIT_NUM (with no accept): saturate at CREDIT_NUM and set err_o.
  - Underflow is impossible, because ready_o is low at 0.
- Framing FSM, advanced on accept only:
  - IDLE: HEAD -> BODY. TAIL, or any non-HEAD type -> set err_o, flit forwarded, stay IDLE.
  - BODY: TAIL -> IDLE, pkt_cnt_o+1. HEAD -> set err_o, forward, stay BODY (new packet). Other types -> stay BODY.
  - Flit types are the `HEAD/`TAIL encodings from params.svh; all other codes are body.
- err_o is sticky until reset.
- Flits are never dropped or reordered.

Optional Feature:
- Macro: NI_PKT_ADMIT_EN.
- Defined: packet-atomic admission. In IDLE, a HEAD flit is accepted only when credit_o >= `PKT_LEN, so ready_o = (state==BODY) ? (credit_o!=0) : (credit_o >= `PKT_LEN). A whole packet then never stalls mid-link, matching the interface send-side head-gating.
- Undefined: per-flit admission as above.
- Requirement when defined: CREDIT_NUM >= `PKT_LEN.

Decomposition:
- Shared package noc_pkg holds:
  - flit_type_t enum (HEAD, BODY, TAIL), mapped to the params.svh encodings.
  - A function flit_type(data) that extracts the top two bits.
  - localparam PKT_CNT_W=16.
- Sub-module credit_counter (parameters CREDIT_NUM, CW; inputs inc, dec; outputs cnt, ovf_err) holds the saturating up/down counter. It is reused by the router's inter-router credit ports.

Test Plan:
- Reset, then send packet H,B,B,T (`PKT_LEN=4) with CREDIT_NUM=16 and no credit_upd -> 4 valid_o pulses at latency 1, same data and order; credit_o=12; pkt_cnt_o=1; err_o=0.
- Stream 20 flits back-to-back with no credit_upd -> ready_o falls after the 16th accept; credit_o=0; valid_i held, no flit lost. Then pulse credit_upd 4 times -> the remaining 4 flits pass; credit_o=0.
- Accept and credit_upd in the same cycle with credit_o=5 -> credit_o stays 5. credit_upd alone at credit_o=16 -> credit_o stays 16, err_o=1.
- Framing errors: BODY flit first after reset -> forwarded, err_o=1. Separately, H,B,H,B,T -> err_o=1, pkt_cnt_o=1.
- Assert rstn low mid-packet (after H,B with credit_o=14) -> all outputs return to reset values immediately; a following full packet completes normally.
- With NI_PKT_ADMIT_EN and credit_o=3 -> HEAD is held (ready_o=0). One credit_upd -> credit_o=4, HEAD accepted next cycle; BODY flits then proceed while credit_o>0.
